// File: rtl/act_pack_writer.sv
// Packs 2/4/8-bit quantized activations from 16 lanes into dense 128-bit words
// and writes them sequentially to the activation SRAM, flushing a partial final word.
module act_pack_writer #(
   parameter int MAX_INPUT_WIDTH = 16,
   parameter int ADDR_WIDTH      = 12,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   fmap_precision,
   input  logic [ADDR_WIDTH-1:0]        base_addr,
   input  logic [CNT_WIDTH-1:0]         num_beats,
   input  logic [8*MAX_INPUT_WIDTH-1:0] din,
   input  logic                         vld_i,
   output logic                         wr_en,
   output logic [ADDR_WIDTH-1:0]        wr_addr,
   output logic [8*MAX_INPUT_WIDTH-1:0] wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int WW = 8 * MAX_INPUT_WIDTH;
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PACK = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r, state_nxt_s;
   logic [1:0]              prec_r;
   logic [CNT_WIDTH-1:0]    num_r;
   logic [CNT_WIDTH-1:0]    beat_cnt_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [1:0]              slot_r;
   logic [WW-1:0]           acc_r;
   logic                    wr_en_r;
   logic [ADDR_WIDTH-1:0]   wr_addr_r;
   logic [WW-1:0]           wr_data_r;
   logic                    done_r, busy_r, err_r;
   logic                    done_nxt_s, busy_nxt_s, err_nxt_s;
   logic                    take_s, last_s, complete_s;
   logic [1:0]              slot_max_s;
   logic [WW-1:0]           merged_s;

   // Place the low b bits of every lane of one beat into slice k of a word.
   function automatic logic [WW-1:0] place_beat(input logic [WW-1:0] d,
                                                input logic [1:0]    p,
                                                input logic [1:0]    k);
      logic [WW-1:0] w;
      int            kk;
      w  = {WW{1'b0}};
      kk = int'(k);
      for (int i = 0; i < MAX_INPUT_WIDTH; i++) begin
         case (p)
            2'b00:   w[kk*(WW/4) + i*2 +: 2] = d[i*8 +: 2];
            2'b01:   w[(kk%2)*(WW/2) + i*4 +: 4] = d[i*8 +: 4];
            default: w[i*8 +: 8] = d[i*8 +: 8];
         endcase
      end
      return w;
   endfunction

   // A beat is only accepted in PACK while beats are still owed; the cycle after
   // the final beat stays in PACK to emit the flush write.
   always_comb begin
      take_s   = (state_r == PACK) && vld_i && (beat_cnt_r != num_r);
      last_s   = (beat_cnt_r == (num_r - CNT_ONE));
      case (prec_r)
         2'b00:   slot_max_s = 2'd3;
         2'b01:   slot_max_s = 2'd1;
         default: slot_max_s = 2'd0;
      endcase
      complete_s = take_s && ((slot_r == slot_max_s) || last_s);
      merged_s   = acc_r | place_beat(din, prec_r, slot_r);
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = (num_beats == CNT_ZERO) ? DONE : PACK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PACK: begin
            if (beat_cnt_r == num_r) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = PACK;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values of the registered status outputs.
   always_comb begin
      done_nxt_s = 1'b0;
      busy_nxt_s = (state_nxt_s != IDLE);
      err_nxt_s  = err_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               done_nxt_s = (num_beats == CNT_ZERO);
               err_nxt_s  = vld_i;
            end else begin
               err_nxt_s  = err_r | vld_i;
            end
         end
         PACK: begin
            done_nxt_s = (beat_cnt_r == num_r);
            err_nxt_s  = err_r | start | (vld_i & ~take_s);
         end
         DONE:    err_nxt_s = err_r | start | vld_i;
         default: err_nxt_s = err_r;
      endcase
   end

   // State register and status output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         done_r  <= done_nxt_s;
         busy_r  <= busy_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // Configuration latch, beat accumulation and SRAM write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         prec_r     <= 2'b00;
         num_r      <= CNT_ZERO;
         beat_cnt_r <= CNT_ZERO;
         addr_r     <= {ADDR_WIDTH{1'b0}};
         slot_r     <= 2'd0;
         acc_r      <= {WW{1'b0}};
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {ADDR_WIDTH{1'b0}};
         wr_data_r  <= {WW{1'b0}};
      end else begin
         wr_en_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  prec_r     <= fmap_precision;
                  num_r      <= num_beats;
                  addr_r     <= base_addr;
                  beat_cnt_r <= CNT_ZERO;
                  slot_r     <= 2'd0;
                  acc_r      <= {WW{1'b0}};
               end
            end
            PACK: begin
               if (take_s) begin
                  beat_cnt_r <= beat_cnt_r + CNT_ONE;
                  if (complete_s) begin
                     wr_en_r   <= 1'b1;
                     wr_addr_r <= addr_r;
                     wr_data_r <= merged_s;
                     addr_r    <= addr_r + ADDR_ONE;
                     acc_r     <= {WW{1'b0}};
                     slot_r    <= 2'd0;
                  end else begin
                     acc_r  <= merged_s;
                     slot_r <= slot_r + 2'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign wr_en   = wr_en_r;
   assign wr_addr = wr_addr_r;
   assign wr_data = wr_data_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign err     = err_r;

endmodule

// File: tb/tb_act_pack_writer.sv
// Self-checking bench for act_pack_writer: directed cases plus randomized layers
// compared against a bit-level packing model.
module tb_act_pack_writer;

   localparam int LANES = 16;
   localparam int AW    = 12;
   localparam int CW    = 16;
   localparam int WW    = 8 * LANES;

   logic          clk = 1'b0;
   logic          rst, start, vld_i;
   logic [1:0]    fmap_precision;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] num_beats;
   logic [WW-1:0] din;
   logic          wr_en, busy, done, err;
   logic [AW-1:0] wr_addr;
   logic [WW-1:0] wr_data;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [WW-1:0] beat_q[$];
   logic [WW-1:0] exp_data;

   act_pack_writer #(.MAX_INPUT_WIDTH(LANES), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .fmap_precision(fmap_precision),
      .base_addr(base_addr), .num_beats(num_beats), .din(din), .vld_i(vld_i),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int ratio(input logic [1:0] p);
      return (p == 2'b00) ? 4 : (p == 2'b01) ? 2 : 1;
   endfunction

   // Word w holds beats w*r .. w*r+r-1; beat slot s keeps b low bits per lane.
   function automatic logic [WW-1:0] model_word(input int w, input int r, input int n);
      int            b    = 8 / r;
      int            sw   = WW / r;
      logic [WW-1:0] word = '0;
      for (int s = 0; s < r; s++) begin
         int k = w * r + s;
         if (k < n) begin
            for (int lane = 0; lane < LANES; lane++)
               for (int t = 0; t < b; t++)
                  word[s*sw + lane*b + t] = beat_q[k][lane*8 + t];
         end
      end
      return word;
   endfunction

   task automatic fill_random(input int n);
      beat_q.delete();
      for (int k = 0; k < n; k++) beat_q.push_back({$urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic run_layer(input logic [1:0] p, input logic [AW-1:0] base, input int n,
                            input bit gaps, input bit inject);
      int            r        = ratio(p);
      int            j        = 0;
      bit            injected = 1'b0;
      logic [AW-1:0] a;
      fmap_precision = p;
      base_addr      = base;
      num_beats      = CW'(n);
      start          = 1'b1;
      tick;
      start          = 1'b0;
      fmap_precision = 2'($urandom);
      base_addr      = AW'($urandom);
      num_beats      = CW'($urandom);
      check("start_err", err, 1'b0);
      check("start_wr", wr_en, 1'b0);
      if (n == 0) begin
         check("zero_done", done, 1'b1);
         tick;
         check("zero_done_drop", done, 1'b0);
         check("zero_busy", busy, 1'b0);
         check("zero_no_wr", wr_en, 1'b0);
         return;
      end
      check("start_done", done, 1'b0);
      check("start_busy", busy, 1'b1);
      while (j < n) begin
         bit beat = !gaps || ($urandom_range(0, 2) != 0);
         if (inject && !injected && j == n / 2) begin
            start    = 1'b1;
            injected = 1'b1;
         end
         vld_i = beat;
         din   = beat ? beat_q[j] : {$urandom, $urandom, $urandom, $urandom};
         tick;
         start = 1'b0;
         vld_i = 1'b0;
         if (beat) begin
            if ((j % r == r - 1) || (j == n - 1)) begin
               a        = base + AW'(j / r);
               exp_data = model_word(j / r, r, n);
               check("wr_en", wr_en, 1'b1);
               check("wr_addr", wr_addr, a);
               check("wr_data", wr_data, exp_data);
            end else begin
               check("wr_idle", wr_en, 1'b0);
            end
            j++;
         end else begin
            check("gap_no_wr", wr_en, 1'b0);
            check("hold_data", wr_data, exp_data);
         end
         check("mid_done", done, 1'b0);
      end
      tick;
      check("done", done, 1'b1);
      check("done_no_wr", wr_en, 1'b0);
      tick;
      check("done_drop", done, 1'b0);
      check("busy_drop", busy, 1'b0);
      check("layer_err", err, inject);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; vld_i = 1'b0; din = '0;
      fmap_precision = 2'b00; base_addr = '0; num_beats = '0;
      tick; tick;
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_wr_addr", wr_addr, '0);
      check("rst_wr_data", wr_data, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      rst = 1'b0;
      exp_data = '0;

      // 8-bit: lane i carries i+1
      beat_q.delete();
      for (int k = 0; k < 3; k++) begin
         logic [WW-1:0] v;
         for (int i = 0; i < LANES; i++) v[i*8 +: 8] = 8'(i + 1);
         beat_q.push_back(v);
      end
      run_layer(2'b10, 12'h010, 3, 1'b0, 1'b0);

      // 4-bit: 0xA5 then 0x3C
      beat_q.delete();
      beat_q.push_back({16{8'hA5}});
      beat_q.push_back({16{8'h3C}});
      run_layer(2'b01, 12'h020, 2, 1'b0, 1'b0);
      check("pk4_const", wr_data, {{16{4'hC}}, {16{4'h5}}});

      // 2-bit partial flush
      beat_q.delete();
      for (int k = 0; k < 5; k++) beat_q.push_back({16{8'hFF}});
      run_layer(2'b00, 12'h100, 5, 1'b0, 1'b0);
      check("pk2_flush_const", wr_data, {96'h0, 32'hFFFF_FFFF});

      // address wrap and zero-length layer
      fill_random(2);
      run_layer(2'b10, 12'hFFF, 2, 1'b0, 1'b0);
      run_layer(2'b01, 12'h055, 0, 1'b0, 1'b0);

      // stray beat while idle
      vld_i = 1'b1;
      din   = {$urandom, $urandom, $urandom, $urandom};
      tick;
      vld_i = 1'b0;
      check("idle_vld_err", err, 1'b1);
      check("idle_vld_no_wr", wr_en, 1'b0);
      fill_random(3);
      run_layer(2'b11, 12'h200, 3, 1'b0, 1'b0);

      // reset after one of four 2-bit beats
      fill_random(1);
      fmap_precision = 2'b00; base_addr = 12'h300; num_beats = 16'd4;
      start = 1'b1; tick; start = 1'b0;
      vld_i = 1'b1; din = beat_q[0]; tick; vld_i = 1'b0;
      rst = 1'b1; tick; rst = 1'b0;
      check("mrst_wr_en", wr_en, 1'b0);
      check("mrst_wr_addr", wr_addr, '0);
      check("mrst_wr_data", wr_data, '0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_done", done, 1'b0);
      check("mrst_err", err, 1'b0);
      exp_data = '0;
      tick;
      check("mrst_no_flush", wr_en, 1'b0);
      check("mrst_idle", busy, 1'b0);
      fill_random(4);
      run_layer(2'b00, 12'h310, 4, 1'b1, 1'b0);

      // start while packing
      fill_random(6);
      run_layer(2'b01, 12'h400, 6, 1'b1, 1'b1);

      // randomized layers
      for (int t = 0; t < 30; t++) begin
         logic [1:0]    p    = 2'($urandom_range(0, 3));
         logic [AW-1:0] base = AW'($urandom);
         int            n    = $urandom_range(0, 10);
         fill_random(n);
         run_layer(p, base, n, 1'b1, (n > 1) && ($urandom_range(0, 4) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
